// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the NOP encoding, the default reset PC
// and the fetch FSM state type.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    VALID = 2'd1,
    ERROR = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: loads RESET_PC on reset, then either holds,
// advances by 4 or loads a redirect target.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  logic [XLEN-1:0] pc_q, pc_d;

  // A load takes priority over an increment; the sum wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target;
    end else if (inc) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction at a time, holds it until the
// core retires it, then follows the sequential or redirected PC.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  input  logic            retire,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_err,
  output logic [XLEN-1:0] retired_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] retired_count_q, retired_count_d;
  logic            fetch_err_q, fetch_err_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            pc_inc, pc_load;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .load    (pc_load),
    .target  (redirect_target),
    .pc      (pc),
    .pc_plus4(pc_plus4)
  );

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    retired_count_d = retired_count_q;
    fetch_err_d     = fetch_err_q;
    pc_inc          = 1'b0;
    pc_load         = 1'b0;
    case (state_q)
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        // A misaligned target still counts as a retire but freezes the PC.
        if (retire) begin
          retired_count_d = retired_count_q + 32'd1;
          if (!redirect) begin
            pc_inc  = 1'b1;
            state_d = REQ;
          end else if (redirect_target[1:0] == 2'b00) begin
            pc_load = 1'b1;
            state_d = REQ;
          end else begin
            fetch_err_d = 1'b1;
            state_d     = ERROR;
          end
        end
      end
      default: begin
        state_d = ERROR;
      end
    endcase
    imem_req_d    = (state_d == REQ);
    instr_valid_d = (state_d == VALID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= REQ;
      instr_q         <= NOP_INSTR;
      retired_count_q <= '0;
      fetch_err_q     <= 1'b0;
      imem_req_q      <= 1'b1;
      instr_valid_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      retired_count_q <= retired_count_d;
      fetch_err_q     <= fetch_err_d;
      imem_req_q      <= imem_req_d;
      instr_valid_q   <= instr_valid_d;
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = pc;
  assign instr         = instr_q;
  assign instr_valid   = instr_valid_q;
  assign fetch_err     = fetch_err_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances (reset PC 0 and 0xFFFF_FFFC)
// share one directed stimulus stream and are compared against a transaction model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        retire;
  logic        redirect;
  logic [31:0] redirect_target;

  logic        o_req[2];
  logic [31:0] o_addr[2];
  logic [31:0] o_instr[2];
  logic [31:0] o_pc[2];
  logic [31:0] o_pc4[2];
  logic        o_valid[2];
  logic        o_err[2];
  logic [31:0] o_count[2];

  // Model: per instance, the PC, the held instruction, whether a fetch is
  // outstanding, whether an instruction is held, the sticky error, the retire count.
  logic [31:0] m_rpc[2];
  logic [31:0] m_pc[2];
  logic [31:0] m_instr[2];
  logic        m_wait[2];
  logic        m_hold[2];
  logic        m_err[2];
  logic [31:0] m_count[2];

  int vectors;
  int miscompares;

  fetch_unit dut0 (
    .clk(clk), .rst(rst),
    .imem_req(o_req[0]), .imem_addr(o_addr[0]),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(o_instr[0]), .pc(o_pc[0]), .pc_plus4(o_pc4[0]),
    .instr_valid(o_valid[0]),
    .retire(retire), .redirect(redirect), .redirect_target(redirect_target),
    .fetch_err(o_err[0]), .retired_count(o_count[0])
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst),
    .imem_req(o_req[1]), .imem_addr(o_addr[1]),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(o_instr[1]), .pc(o_pc[1]), .pc_plus4(o_pc4[1]),
    .instr_valid(o_valid[1]),
    .retire(retire), .redirect(redirect), .redirect_target(redirect_target),
    .fetch_err(o_err[1]), .retired_count(o_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report it when it differs.
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Check every output of both instances against the model.
  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      compare($sformatf("imem_req%0d", i), {31'd0, o_req[i]}, {31'd0, m_wait[i] && !m_err[i]});
      if (m_wait[i] && !m_err[i]) compare($sformatf("imem_addr%0d", i), o_addr[i], m_pc[i]);
      compare($sformatf("pc%0d", i), o_pc[i], m_pc[i]);
      compare($sformatf("pc_plus4_%0d", i), o_pc4[i], m_pc[i] + 32'd4);
      compare($sformatf("instr%0d", i), o_instr[i], m_instr[i]);
      compare($sformatf("instr_valid%0d", i), {31'd0, o_valid[i]}, {31'd0, m_hold[i]});
      compare($sformatf("fetch_err%0d", i), {31'd0, o_err[i]}, {31'd0, m_err[i]});
      compare($sformatf("retired_count%0d", i), o_count[i], m_count[i]);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pc[i] = m_rpc[i]; m_instr[i] = 32'h0000_0013;
        m_wait[i] = 1'b1; m_hold[i] = 1'b0; m_err[i] = 1'b0; m_count[i] = '0;
      end else if (m_err[i]) begin
        // stuck until reset
      end else if (m_wait[i]) begin
        if (imem_ack) begin
          m_instr[i] = imem_rdata; m_wait[i] = 1'b0; m_hold[i] = 1'b1;
        end
      end else if (m_hold[i] && retire) begin
        m_count[i] = m_count[i] + 32'd1;
        m_hold[i]  = 1'b0;
        if (!redirect) begin
          m_pc[i] = m_pc[i] + 32'd4; m_wait[i] = 1'b1;
        end else if (redirect_target % 4 == 0) begin
          m_pc[i] = redirect_target; m_wait[i] = 1'b1;
        end else begin
          m_err[i] = 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, check outputs, clock, update the model.
  task automatic applyStimulus(input logic r, input logic ack, input logic [31:0] rdata,
                               input logic ret, input logic redir, input logic [31:0] tgt);
    rst = r; imem_ack = ack; imem_rdata = rdata;
    retire = ret; redirect = redir; redirect_target = tgt;
    #1;
    checkOutput();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_rpc[0] = 32'h0000_0000; m_rpc[1] = 32'hFFFF_FFFC;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    retire = 1'b0; redirect = 1'b0; redirect_target = '0;
    @(posedge clk);
    modelStep();
    @(negedge clk);

    // Reset with a simultaneous ack that must be dropped.
    applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    compare("reset_instr", o_instr[0], 32'h0000_0013);
    compare("reset_req", {31'd0, o_req[0]}, 32'd1);
    compare("reset_addr1", o_addr[1], 32'hFFFF_FFFC);
    compare("reset_pc4_wrap", o_pc4[1], 32'h0000_0000);

    // Zero-wait fetch on the first request cycle.
    applyStimulus(0, 1, 32'h0050_0093, 0, 0, 0);
    compare("first_valid", {31'd0, o_valid[0]}, 32'd1);
    compare("first_instr", o_instr[0], 32'h0050_0093);
    compare("first_pc", o_pc[0], 32'h0000_0000);
    compare("first_pc4", o_pc4[0], 32'h0000_0004);

    // Redirect without retire and stray acks are ignored while holding.
    applyStimulus(0, 1, 32'h1111_1111, 0, 1, 32'h0000_0200);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0203);
    // Sequential retire.
    applyStimulus(0, 0, 32'h0, 1, 0, 0);
    compare("wrap_addr1", o_addr[1], 32'h0000_0000);
    compare("seq_addr0", o_addr[0], 32'h0000_0004);

    // Three wait cycles before the ack.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 32'hBAD0_0000, 0, 1, 0);
      compare("wait_req", {31'd0, o_req[0]}, 32'd1);
      compare("wait_addr", o_addr[0], 32'h0000_0004);
    end
    applyStimulus(0, 1, 32'h0010_0113, 0, 0, 0);
    compare("wait_instr", o_instr[0], 32'h0010_0113);

    // Aligned redirect.
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0100);
    compare("redir_addr", o_addr[0], 32'h0000_0100);
    compare("redir_count", o_count[0], 32'd2);
    applyStimulus(0, 1, 32'h0020_0193, 0, 0, 0);

    // Misaligned redirect enters the sticky error state.
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0102);
    compare("err_flag", {31'd0, o_err[0]}, 32'd1);
    compare("err_pc", o_pc[0], 32'h0000_0100);
    compare("err_count", o_count[0], 32'd3);
    applyStimulus(0, 1, 32'h0030_0213, 1, 0, 0);
    applyStimulus(0, 1, 32'h0040_0293, 1, 1, 32'h0000_0400);
    compare("err_sticky_req", {31'd0, o_req[0]}, 32'd0);
    compare("err_sticky_valid", {31'd0, o_valid[0]}, 32'd0);

    // Reset out of error, then reset again while a request is pending with an ack.
    applyStimulus(1, 0, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    applyStimulus(1, 1, 32'hCAFE_F00D, 0, 0, 0);
    compare("rst_req_instr", o_instr[0], 32'h0000_0013);
    compare("rst_req_pc", o_pc[0], 32'h0000_0000);
    compare("rst_req_valid", {31'd0, o_valid[0]}, 32'd0);
    compare("rst_req_req", {31'd0, o_req[0]}, 32'd1);
    compare("rst_req_err", {31'd0, o_err[0]}, 32'd0);

    // A short run of back-to-back fetch/retire pairs.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 32'h0000_0013 + (k << 7), 0, 0, 0);
      applyStimulus(0, 0, 32'h0, 1, 0, 0);
    end
    compare("burst_pc", o_pc[0], 32'h0000_0010);
    compare("burst_count", o_count[0], 32'd4);
    applyStimulus(0, 0, 32'h0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; SHALL be word-aligned.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  read address; equals pc whenever imem_req=1.
REQ-006 imem_ack  in  1  memory returns imem_rdata this cycle; ignored unless imem_req=1.
REQ-007 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-008 instr  out  32  registered instruction word driven to the control decoder and register file.
REQ-009 pc  out  32  address of the current instruction.
REQ-010 pc_plus4  out  32  pc+4, modulo 2^32, for JAL/JALR link writeback.
REQ-011 instr_valid  out  1  instr/pc hold a fetched instruction.
REQ-012 retire  in  1  core has completed instr; sampled only when instr_valid=1.
REQ-013 redirect  in  1  taken branch/JAL/JALR; sampled only with retire=1.
REQ-014 redirect_target  in  32  next PC when redirect=1.
REQ-015 fetch_err  out  1  misaligned redirect target detected; sticky.
REQ-016 retired_count  out  32  number of retired instructions, wraps modulo 2^32.

Function
REQ-017 The FSM SHALL have three states: REQ, VALID, ERROR.
REQ-018 REQ: imem_req=1, imem_addr=pc, instr_valid=0; imem_ack=1 -> instr<=imem_rdata, go to VALID; otherwise stay, holding req and addr stable.
REQ-019 imem_ack SHALL be accepted in the same cycle imem_req rises (zero-wait memory); minimum throughput is one instruction per 2 cycles.
REQ-020 VALID: imem_req=0, instr_valid=1, instr and pc held stable until retire=1.
REQ-021 VALID with retire=1, redirect=0 -> pc<=pc+4, go to REQ.
REQ-022 VALID with retire=1, redirect=1, redirect_target[1:0]==0 -> pc<=redirect_target, go to REQ.
REQ-023 VALID with retire=1, redirect=1, redirect_target[1:0]!=0 -> pc unchanged, fetch_err<=1, go to ERROR.
REQ-024 redirect with retire=0, and retire in REQ or ERROR, SHALL be ignored.
REQ-025 retired_count SHALL increment by 1 on every accepted retire (VALID with retire=1), including the one that enters ERROR.
REQ-026 ERROR: imem_req=0, instr_valid=0, fetch_err=1; exited only by rst.
REQ-027 PC at 32'hFFFF_FFFC with sequential retire SHALL wrap to 32'h0000_0000; pc_plus4 wraps likewise.
REQ-028 imem_ack asserted in VALID or ERROR SHALL have no effect on any state or output.

Reset
REQ-029 When rst=1 at a clock edge, in any state including REQ awaiting ack: pc<=RESET_PC, state<=REQ, instr<=32'h0000_0013 (NOP), fetch_err<=0, retired_count<=0.
REQ-030 During the first cycle after reset, imem_req=1 and imem_addr=RESET_PC; instr_valid=0.
REQ-031 An imem_ack arriving in the same cycle as rst=1 SHALL be discarded.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the fetch state typedef (REQ/VALID/ERROR), XLEN=32, the NOP encoding 32'h0000_0013 and the default RESET_PC.
REQ-033 One sub-module pc_reg (PC register with reset-load, increment-by-4 and load-target ports) SHALL be instantiated; the FSM and instruction register stay in fetch_unit.

Verification
REQ-034 Reset, then ack on the first REQ cycle with rdata=32'h0050_0093 -> next cycle instr_valid=1, instr=32'h0050_0093, pc=0, pc_plus4=4.
REQ-035 Memory acks after 3 wait cycles -> imem_req and imem_addr stay stable for 4 cycles, instr_valid=0 throughout.
REQ-036 retire+redirect with target=32'h0000_0100 -> the next REQ cycle has imem_addr=32'h100 and retired_count increments by 1.
REQ-037 retire+redirect with target=32'h0000_0102 -> fetch_err=1, imem_req=0 and instr_valid=0 until rst; pc unchanged.
REQ-038 RESET_PC=32'hFFFF_FFFC with sequential retire -> the next imem_addr=32'h0000_0000.
REQ-039 rst asserted while in REQ awaiting ack, with ack in the same cycle -> instr=NOP, pc=RESET_PC, instr_valid=0, and a new request is issued.
